// File: rtl/etapa_id_ex_pkg.sv
// mips_defs: shared definitions for the MIPS pipeline stages.
//   CTRL_W            width of the decoded control bus
//   CTRL_* indices    bit positions inside the control bus
//   REG_W, REG_ZERO   register-specifier width and the hard-wired $0
//   wbHits()          true when a WB write targets a given read register
package mips_defs;

   localparam int CTRL_W        = 8;
   localparam int CTRL_REGWRITE = 0;
   localparam int CTRL_MEMREAD  = 1;
   localparam int CTRL_MEMWRITE = 2;
   localparam int CTRL_MEMTOREG = 3;
   localparam int CTRL_ALUSRC   = 4;
   localparam int CTRL_REGDST   = 5;
   localparam int CTRL_ALUOP    = 6;   // LSB of the 2-bit ALUOp field
   localparam int ALUOP_W       = 2;

   localparam int         REG_W    = 5;
   localparam logic [4:0] REG_ZERO = 5'd0;

   // $0 is never forwarded: writes to it are discarded by the register file.
   function automatic logic wbHits(input logic we,
                                   input logic [REG_W-1:0] wreg,
                                   input logic [REG_W-1:0] rreg);
      return we && (wreg != REG_ZERO) && (wreg == rreg);
   endfunction

endpackage

// File: rtl/etapa_id_ex_unidad_riesgos.sv
// unidad_riesgos: load-use hazard detector.
//   idValid, idRs, idRt   instruction currently in ID
//   exValid, exMemRead    instruction in EX is a real load
//   exRt                  load destination
//   stall                 hold PC and IF/ID for one cycle (combinational)
// The comparison against rt is made even when the ID instruction does not
// read rt; this costs an occasional needless bubble but keeps decode simple.
module unidad_riesgos
   import mips_defs::*;
(
   input  logic             idValid,
   input  logic [REG_W-1:0] idRs,
   input  logic [REG_W-1:0] idRt,
   input  logic             exValid,
   input  logic             exMemRead,
   input  logic [REG_W-1:0] exRt,
   output logic             stall
);

   assign stall = idValid && exValid && exMemRead && (exRt != REG_ZERO) &&
                  ((exRt == idRs) || (exRt == idRt));

endmodule

// File: rtl/etapa_id_ex.sv
// etapa_id_ex: ID->EX pipeline register with WB->ID write-through bypass,
// load-use bubble insertion and branch flush.
//   clk, reset            clock; asynchronous active-high reset
//   id_*                  decoded instruction and register-file read data
//   wb_regwrite/wreg/wdata WB-stage register-file write, forwarded into ID
//   flush                 taken branch/jump in EX: kill the incoming slot
//   stall                 load-use hazard towards PC and IF/ID (combinational)
//   ex_*                  registered EX-stage fields (ex_ctrl is 0 in a bubble)
//   stall_count           saturating number of bubbles caused by stall
module etapa_id_ex #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic [4:0]        id_rs,
   input  logic [4:0]        id_rt,
   input  logic [4:0]        id_rd,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [DATA_W-1:0] id_rdata1,
   input  logic [DATA_W-1:0] id_rdata2,
   input  logic              wb_regwrite,
   input  logic [4:0]        wb_wreg,
   input  logic [DATA_W-1:0] wb_wdata,
   input  logic              flush,
   output logic              stall,
   output logic              ex_valid,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [4:0]        ex_rs,
   output logic [4:0]        ex_rt,
   output logic [4:0]        ex_rd,
   output logic [DATA_W-1:0] ex_a,
   output logic [DATA_W-1:0] ex_b,
   output logic [DATA_W-1:0] ex_imm,
   output logic [CNT_W-1:0]  stall_count
);

   import mips_defs::*;

   logic              exValidReg;
   logic [CTRL_W-1:0] exCtrlReg;
   logic [REG_W-1:0]  exRsReg;
   logic [REG_W-1:0]  exRtReg;
   logic [REG_W-1:0]  exRdReg;
   logic [DATA_W-1:0] exAReg;
   logic [DATA_W-1:0] exBReg;
   logic [DATA_W-1:0] exImmReg;
   logic [CNT_W-1:0]  stallCountReg;
   logic              hazard;

   // Bypass: the register file writes on the same edge that captures ID/EX,
   // so a WB write to a source register this cycle is forwarded directly.
   logic [DATA_W-1:0] rdataArr [2];
   logic [REG_W-1:0]  srcReg   [2];
   logic [DATA_W-1:0] opnd     [2];

   assign rdataArr[0] = id_rdata1;
   assign rdataArr[1] = id_rdata2;
   assign srcReg[0]   = id_rs;
   assign srcReg[1]   = id_rt;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : gBypass
         assign opnd[gi] = wbHits(wb_regwrite, wb_wreg, srcReg[gi]) ? wb_wdata
                                                                    : rdataArr[gi];
      end
   endgenerate

   unidad_riesgos uRiesgos (
      .idValid   (id_valid),
      .idRs      (id_rs),
      .idRt      (id_rt),
      .exValid   (exValidReg),
      .exMemRead (exCtrlReg[CTRL_MEMREAD]),
      .exRt      (exRtReg),
      .stall     (hazard)
   );

   // Flush outranks stall: the instruction that caused the hazard is being
   // squashed anyway, so the bubble is not attributed to the load.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         exValidReg    <= 1'b0;
         exCtrlReg     <= '0;
         exRsReg       <= '0;
         exRtReg       <= '0;
         exRdReg       <= '0;
         exAReg        <= '0;
         exBReg        <= '0;
         exImmReg      <= '0;
         stallCountReg <= '0;
      end else if (flush) begin
         exValidReg <= 1'b0;
         exCtrlReg  <= '0;
      end else if (hazard) begin
         exValidReg <= 1'b0;
         exCtrlReg  <= '0;
         if (stallCountReg != '1)
            stallCountReg <= stallCountReg + CNT_W'(1);
      end else begin
         exValidReg <= id_valid;
         exCtrlReg  <= id_valid ? id_ctrl : '0;
         exRsReg    <= id_rs;
         exRtReg    <= id_rt;
         exRdReg    <= id_rd;
         exImmReg   <= id_imm;
         exAReg     <= opnd[0];
         exBReg     <= opnd[1];
      end
   end

   assign stall       = hazard;
   assign ex_valid    = exValidReg;
   assign ex_ctrl     = exCtrlReg;
   assign ex_rs       = exRsReg;
   assign ex_rt       = exRtReg;
   assign ex_rd       = exRdReg;
   assign ex_a        = exAReg;
   assign ex_b        = exBReg;
   assign ex_imm      = exImmReg;
   assign stall_count = stallCountReg;

endmodule

// File: tb/tb_etapa_id_ex.sv
module tb_etapa_id_ex;

   localparam int DATA_W = 32;
   localparam int CTRL_W = 8;
   localparam int CNT_W  = 4;

   // Control encodings: add = RegWrite|RegDst|ALUOp=10, lw = RegWrite|MemRead|MemtoReg|ALUSrc
   localparam logic [7:0] C_ADD = 8'hA1;
   localparam logic [7:0] C_LW  = 8'h1B;

   logic              clk = 1'b0;
   logic              reset;
   logic              id_valid;
   logic [CTRL_W-1:0] id_ctrl;
   logic [4:0]        id_rs, id_rt, id_rd;
   logic [DATA_W-1:0] id_imm, id_rdata1, id_rdata2;
   logic              wb_regwrite;
   logic [4:0]        wb_wreg;
   logic [DATA_W-1:0] wb_wdata;
   logic              flush;
   logic              stall;
   logic              ex_valid;
   logic [CTRL_W-1:0] ex_ctrl;
   logic [4:0]        ex_rs, ex_rt, ex_rd;
   logic [DATA_W-1:0] ex_a, ex_b, ex_imm;
   logic [CNT_W-1:0]  stall_count;

   etapa_id_ex #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .id_valid(id_valid), .id_ctrl(id_ctrl), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_imm(id_imm), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2),
      .wb_regwrite(wb_regwrite), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
      .flush(flush), .stall(stall),
      .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
      .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        valid;
      logic [7:0]  ctrl;
      logic [4:0]  rs, rt, rd;
      logic [31:0] a, b, imm;
      logic [3:0]  cnt;
      string       tag;
   } exp_t;

   exp_t expQ[$];
   int checks = 0;
   int passed = 0;

   // Reference state of the EX slot, updated as each vector is issued.
   logic        mValid;
   logic [7:0]  mCtrl;
   logic [4:0]  mRs, mRt, mRd;
   logic [31:0] mA, mB, mImm;
   logic [3:0]  mCnt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passed++;
      else $display("FAIL %s: got %h, expected %h", name, act, req);
   endtask

   task automatic modelReset();
      mValid = 0; mCtrl = 0; mRs = 0; mRt = 0; mRd = 0;
      mA = 0; mB = 0; mImm = 0; mCnt = 0;
   endtask

   // Apply one ID vector at the falling edge, check stall, push the expected EX state.
   task automatic step(input logic v, input logic [7:0] ctrl,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] imm,
                       input logic wbwe, input logic [4:0] wbr, input logic [31:0] wbd,
                       input logic fl, input string tag);
      logic expStall;
      exp_t e;
      @(negedge clk);
      id_valid = v; id_ctrl = ctrl; id_rs = rs; id_rt = rt; id_rd = rd;
      id_rdata1 = r1; id_rdata2 = r2; id_imm = imm;
      wb_regwrite = wbwe; wb_wreg = wbr; wb_wdata = wbd; flush = fl;
      #1;
      expStall = v && mValid && mCtrl[1] && (mRt != 5'd0) && (mRt == rs || mRt == rt);
      check({"stall_", tag}, {31'd0, stall}, {31'd0, expStall});
      if (fl) begin
         mValid = 0; mCtrl = 0;
      end else if (expStall) begin
         mValid = 0; mCtrl = 0;
         if (mCnt != 4'hF) mCnt = mCnt + 4'd1;
      end else begin
         mValid = v; mCtrl = v ? ctrl : 8'h00;
         mRs = rs; mRt = rt; mRd = rd; mImm = imm;
         mA = (wbwe && wbr != 5'd0 && wbr == rs) ? wbd : r1;
         mB = (wbwe && wbr != 5'd0 && wbr == rt) ? wbd : r2;
      end
      e.valid = mValid; e.ctrl = mCtrl; e.rs = mRs; e.rt = mRt; e.rd = mRd;
      e.a = mA; e.b = mB; e.imm = mImm; e.cnt = mCnt; e.tag = tag;
      expQ.push_back(e);
   endtask

   task automatic idle(input string tag);
      step(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, tag);
   endtask

   // Monitor: one transaction per rising edge while expectations are pending.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            $display("txn %s: valid=%0d ctrl=%h a=%h b=%h cnt=%0d",
                     e.tag, ex_valid, ex_ctrl, ex_a, ex_b, stall_count);
            check({"valid_", e.tag}, {31'd0, ex_valid}, {31'd0, e.valid});
            check({"ctrl_", e.tag}, {24'd0, ex_ctrl}, {24'd0, e.ctrl});
            check({"cnt_", e.tag}, {28'd0, stall_count}, {28'd0, e.cnt});
            if (e.valid) begin
               check({"rs_", e.tag}, {27'd0, ex_rs}, {27'd0, e.rs});
               check({"rt_", e.tag}, {27'd0, ex_rt}, {27'd0, e.rt});
               check({"rd_", e.tag}, {27'd0, ex_rd}, {27'd0, e.rd});
               check({"a_", e.tag}, ex_a, e.a);
               check({"b_", e.tag}, ex_b, e.b);
               check({"imm_", e.tag}, ex_imm, e.imm);
            end
         end
      end
   end

   initial begin
      reset = 1; id_valid = 0; id_ctrl = 0; id_rs = 0; id_rt = 0; id_rd = 0;
      id_imm = 0; id_rdata1 = 0; id_rdata2 = 0;
      wb_regwrite = 0; wb_wreg = 0; wb_wdata = 0; flush = 0;
      modelReset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", {31'd0, ex_valid}, 32'd0);
      check("rst_cnt", {28'd0, stall_count}, 32'd0);
      @(negedge clk);
      reset = 0;

      // Bypass: WB writes rs -> forwarded; $0 write is not forwarded; rt bypass.
      step(1, C_ADD, 3, 4, 9, 32'h11, 32'h22, 32'h5, 1, 3, 32'hAA, 0, "byp_rs");
      @(posedge clk); #2;
      check("hand_byp_rs", ex_a, 32'hAA);
      step(1, C_ADD, 3, 4, 9, 32'h11, 32'h22, 32'h5, 1, 0, 32'hAA, 0, "byp_r0");
      @(posedge clk); #2;
      check("hand_byp_r0", ex_a, 32'h11);
      step(1, C_ADD, 0, 4, 9, 32'h0, 32'h22, 32'h7, 1, 4, 32'hBB, 0, "byp_rt");
      step(1, C_ADD, 3, 4, 9, 32'h11, 32'h22, 32'h5, 0, 3, 32'hCC, 0, "byp_nowe");

      // Load-use: lw rt=5 then add rs=5 -> one bubble, then the add enters.
      step(1, C_LW, 2, 5, 0, 32'h100, 32'h0, 32'h4, 0, 0, 0, 0, "lw5");
      step(1, C_ADD, 5, 6, 7, 32'h33, 32'h44, 32'h0, 0, 0, 0, 0, "use5_stall");
      @(posedge clk); #2;
      check("hand_cnt_1", {28'd0, stall_count}, 32'd1);
      step(1, C_ADD, 5, 6, 7, 32'h33, 32'h44, 32'h0, 0, 0, 0, 0, "use5_go");

      // No hazard: load into $0, and a consumer of unrelated registers.
      step(1, C_LW, 2, 0, 0, 32'h100, 32'h0, 32'h4, 0, 0, 0, 0, "lw0");
      step(1, C_ADD, 0, 0, 7, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, "use0");
      step(1, C_LW, 2, 5, 0, 32'h100, 32'h0, 32'h4, 0, 0, 0, 0, "lw5b");
      step(1, C_ADD, 6, 6, 7, 32'h55, 32'h55, 32'h0, 0, 0, 0, 0, "use6");
      // Consumer via rt, and an invalid ID slot behind a load.
      step(1, C_LW, 2, 8, 0, 32'h100, 32'h0, 32'h4, 0, 0, 0, 0, "lw8");
      step(1, C_ADD, 1, 8, 7, 32'h1, 32'h2, 32'h0, 0, 0, 0, 0, "use8rt");
      step(1, C_LW, 2, 8, 0, 32'h100, 32'h0, 32'h4, 0, 0, 0, 0, "lw8b");
      step(0, C_ADD, 8, 8, 7, 32'h1, 32'h2, 32'h0, 0, 0, 0, 0, "noval");

      // Flush together with a load-use hazard: flush wins, no count.
      step(1, C_LW, 2, 5, 0, 32'h100, 32'h0, 32'h4, 0, 0, 0, 0, "lw5c");
      step(1, C_ADD, 5, 6, 7, 32'h33, 32'h44, 32'h0, 0, 0, 0, 1, "flush_haz");
      step(1, C_ADD, 1, 2, 3, 32'h9, 32'hA, 32'h0, 0, 0, 0, 1, "flush_plain");

      // Reset mid-stall: stall drops at once, everything clears.
      step(1, C_LW, 2, 5, 0, 32'h100, 32'h0, 32'h4, 0, 0, 0, 0, "lw5d");
      @(negedge clk);
      id_valid = 1; id_ctrl = C_ADD; id_rs = 5; id_rt = 6; flush = 0;
      #1;
      check("pre_rst_stall", {31'd0, stall}, 32'd1);
      reset = 1;
      #1;
      check("rst_stall", {31'd0, stall}, 32'd0);
      check("rst_valid2", {31'd0, ex_valid}, 32'd0);
      check("rst_ctrl", {24'd0, ex_ctrl}, 32'd0);
      check("rst_a", ex_a, 32'd0);
      check("rst_b", ex_b, 32'd0);
      check("rst_imm", ex_imm, 32'd0);
      check("rst_regs", {17'd0, ex_rs, ex_rt, ex_rd}, 32'd0);
      check("rst_cnt2", {28'd0, stall_count}, 32'd0);
      modelReset();
      @(negedge clk);
      reset = 0; id_valid = 0;

      // Saturation: 17 load-use stalls on a 4-bit counter.
      for (int i = 0; i < 17; i++) begin
         step(1, C_LW, 2, 7, 0, 32'h200, 32'h0, 32'h8, 0, 0, 0, 0, "sat_lw");
         step(1, C_ADD, 7, 1, 3, 32'h1, 32'h2, 32'h0, 0, 0, 0, 0, "sat_use");
      end
      @(posedge clk); #2;
      check("hand_sat", {28'd0, stall_count}, 32'hF);
      idle("tail");

      // Bounded drain of the scoreboard.
      repeat (3) @(posedge clk);
      #2;
      check("drain_empty", expQ.size(), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
